// File: rtl/pipeline_exec_controller_if.sv
// pipeline_exec_controller_if: host command and pipeline control bundle for the execution controller
interface pipeline_exec_controller_if #(
    parameter int CYCLE_W = 32
);
    logic               cmd_valid;
    logic [1:0]         cmd;
    logic               cmd_ready;
    logic               halt_in_wb;
    logic               pipe_en;
    logic               pipe_flush;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [CYCLE_W-1:0] cycle_count;
    logic [2:0]         state;
    modport master (
        output cmd_valid, cmd, halt_in_wb,
        input  cmd_ready, pipe_en, pipe_flush, busy, done, timeout, cycle_count, state
    );
    modport slave (
        input  cmd_valid, cmd, halt_in_wb,
        output cmd_ready, pipe_en, pipe_flush, busy, done, timeout, cycle_count, state
    );
endinterface

// File: rtl/pipeline_exec_controller.sv
// pipeline_exec_controller: run/step/abort sequencing, global enable/flush, cycle counter and watchdog
module pipeline_exec_controller #(
    parameter int CYCLE_W    = 32,
    parameter int MAX_CYCLES = 1000000
) (
    input logic                        clk,
    input logic                        reset_n,
    pipeline_exec_controller_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, INIT, RUN, STEP_WAIT, STEP_EXEC, DONE} stateT;
    localparam logic [1:0] CMD_RUN = 2'b00, CMD_STEP_MODE = 2'b01, CMD_STEP = 2'b10, CMD_ABORT = 2'b11;
    stateT              stateQ, stateD;
    logic               stepModeQ, stepModeD;
    logic               timeoutQ, timeoutD;
    logic [CYCLE_W-1:0] countQ, countD;
    logic               start, abort, cmdRun, cmdStep, wdHit;
    logic [CYCLE_W-1:0] countInc;
    assign cmdRun   = bus.cmd_valid && bus.cmd == CMD_RUN;
    assign cmdStep  = bus.cmd_valid && bus.cmd == CMD_STEP;
    assign abort    = bus.cmd_valid && bus.cmd == CMD_ABORT;
    assign start    = bus.cmd_valid && (bus.cmd == CMD_RUN || bus.cmd == CMD_STEP_MODE);
    assign countInc = countQ + 1'b1;
    assign wdHit    = MAX_CYCLES != 0 && countInc == CYCLE_W'(MAX_CYCLES);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stateQ    <= IDLE;
            stepModeQ <= 1'b0;
            timeoutQ  <= 1'b0;
            countQ    <= '0;
        end else begin
            stateQ    <= stateD;
            stepModeQ <= stepModeD;
            timeoutQ  <= timeoutD;
            countQ    <= countD;
        end
    end
    always_comb begin
        stateD    = stateQ;
        stepModeD = stepModeQ;
        timeoutD  = timeoutQ;
        countD    = countQ;
        case (stateQ)
            IDLE, DONE: begin
                // counters are cleared on entry so INIT already shows the fresh values
                if (start) begin
                    stateD    = INIT;
                    stepModeD = bus.cmd == CMD_STEP_MODE;
                    countD    = '0;
                    timeoutD  = 1'b0;
                end else if (abort) begin
                    stateD   = IDLE;
                    timeoutD = 1'b0;
                end
            end
            INIT: stateD = stepModeQ ? STEP_WAIT : RUN;
            RUN, STEP_EXEC: begin
                countD = countInc;
                if (abort) stateD = IDLE;
                else if (bus.halt_in_wb) stateD = DONE;
                else if (wdHit) begin
                    stateD   = DONE;
                    timeoutD = 1'b1;
                end else stateD = stateQ == RUN ? RUN : STEP_WAIT;
            end
            STEP_WAIT: stateD = cmdStep ? STEP_EXEC : cmdRun ? RUN : abort ? IDLE : STEP_WAIT;
            default: stateD = IDLE;
        endcase
    end
    assign bus.cmd_ready   = 1'b1;
    assign bus.pipe_en     = stateQ == RUN || stateQ == STEP_EXEC;
    assign bus.pipe_flush  = stateQ == INIT;
    assign bus.busy        = stateQ == INIT || stateQ == RUN || stateQ == STEP_WAIT || stateQ == STEP_EXEC;
    assign bus.done        = stateQ == DONE;
    assign bus.timeout     = timeoutQ;
    assign bus.cycle_count = countQ;
    assign bus.state       = stateQ;
endmodule

// File: tb/tb_pipeline_exec_controller.sv
// tb_pipeline_exec_controller: directed plan plus random commands against a behavioural model
module tb_pipeline_exec_controller;
    localparam int MAXC = 20;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int nCompared = 0;
    int nMismatched = 0;
    int mState = 0;
    bit mStepMode = 1'b0;
    bit mTimeout = 1'b0;
    logic [31:0] mCount = '0;
    pipeline_exec_controller_if #(.CYCLE_W(32)) bus();
    pipeline_exec_controller #(.CYCLE_W(32), .MAX_CYCLES(MAXC)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick(input bit rn, input bit v, input logic [1:0] c, input bit h);
        bit en;
        @(negedge clk);
        reset_n = rn;
        bus.cmd_valid = v;
        bus.cmd = c;
        bus.halt_in_wb = h;
        @(posedge clk);
        en = mState == 2 || mState == 4;
        if (!rn) begin
            mState = 0;
            mCount = 0;
            mTimeout = 0;
        end else if (en) begin
            mCount = mCount + 1;
            if (v && c == 3) mState = 0;
            else if (h) mState = 5;
            else if (mCount == MAXC) begin
                mState = 5;
                mTimeout = 1;
            end else if (mState == 4) mState = 3;
        end else if (mState == 1) mState = mStepMode ? 3 : 2;
        else if (mState == 3 && v) mState = c == 2 ? 4 : c == 0 ? 2 : c == 3 ? 0 : 3;
        else if ((mState == 0 || mState == 5) && v) begin
            if (c <= 1) begin
                mState = 1;
                mStepMode = c == 1;
                mCount = 0;
                mTimeout = 0;
            end else if (c == 3) begin
                mState = 0;
                mTimeout = 0;
            end
        end
        #1;
        check("state", 32'(bus.state), 32'(mState));
        check("pipe_en", 32'(bus.pipe_en), 32'(mState == 2 || mState == 4));
        check("pipe_flush", 32'(bus.pipe_flush), 32'(mState == 1));
        check("busy", 32'(bus.busy), 32'(mState >= 1 && mState <= 4));
        check("done", 32'(bus.done), 32'(mState == 5));
        check("timeout", 32'(bus.timeout), 32'(mTimeout));
        check("cycle_count", bus.cycle_count, mCount);
        check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 2'b00, 0);
    endtask
    initial begin
        bus.cmd_valid = 0;
        bus.cmd = 0;
        bus.halt_in_wb = 0;
        tick(0, 0, 2'b00, 0);
        tick(0, 0, 2'b00, 0);
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_count", bus.cycle_count, 32'd0);
        tick(1, 1, 2'b00, 0);
        check("run_flush", 32'(bus.pipe_flush), 32'd1);
        tick(1, 0, 2'b00, 0);
        check("run_en", 32'(bus.pipe_en), 32'd1);
        idle(9);
        tick(1, 0, 2'b00, 1);
        check("halt_count", bus.cycle_count, 32'd10);
        check("halt_state", 32'(bus.state), 32'd5);
        check("halt_timeout", 32'(bus.timeout), 32'd0);
        tick(1, 1, 2'b01, 0);
        check("restart_done", 32'(bus.done), 32'd0);
        check("restart_count", bus.cycle_count, 32'd0);
        tick(1, 0, 2'b00, 0);
        for (int s = 0; s < 3; s++) begin
            tick(1, 1, 2'b10, 0);
            check("step_en", 32'(bus.pipe_en), 32'd1);
            tick(1, 1, 2'b10, 0);
            check("step_ignored", 32'(bus.state), 32'd3);
            idle(2);
        end
        check("step_count", bus.cycle_count, 32'd3);
        tick(1, 1, 2'b00, 0);
        check("cont_flush", 32'(bus.pipe_flush), 32'd0);
        idle(5);
        check("cont_count", bus.cycle_count, 32'd8);
        tick(1, 1, 2'b11, 1);
        check("abort_state", 32'(bus.state), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        tick(1, 1, 2'b00, 0);
        tick(1, 0, 2'b00, 0);
        idle(19);
        check("wd_pre", 32'(bus.state), 32'd2);
        tick(1, 0, 2'b00, 0);
        check("wd_count", bus.cycle_count, 32'd20);
        check("wd_timeout", 32'(bus.timeout), 32'd1);
        tick(1, 0, 2'b00, 0);
        check("wd_en_low", 32'(bus.pipe_en), 32'd0);
        tick(1, 1, 2'b00, 0);
        check("wd_restart_to", 32'(bus.timeout), 32'd0);
        tick(1, 0, 2'b00, 0);
        idle(19);
        tick(1, 0, 2'b00, 1);
        check("wd_halt_to", 32'(bus.timeout), 32'd0);
        check("wd_halt_done", 32'(bus.done), 32'd1);
        tick(1, 1, 2'b00, 0);
        tick(1, 0, 2'b00, 0);
        idle(7);
        check("mid_count", bus.cycle_count, 32'd7);
        tick(0, 0, 2'b00, 0);
        check("mid_reset_state", 32'(bus.state), 32'd0);
        check("mid_reset_count", bus.cycle_count, 32'd0);
        tick(1, 1, 2'b10, 0);
        check("idle_step", 32'(bus.state), 32'd0);
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(199) != 0, $urandom_range(3) == 0, 2'($urandom_range(3)), $urandom_range(15) == 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
